// File: rtl/rob_commit.sv
// In-order retirement stage: pops the ROB head once it is complete, writes register
// results to the regfile and sends stores to data memory through a req/ack handshake.
module rob_commit #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rob_empty,
    input  logic [31:0]      rob_head_instr,
    input  logic [31:0]      rob_head_val,
    input  logic             rob_head_ready,
    output logic             rob_pop,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [4:0]       rf_raddr,
    input  logic [31:0]      rf_rdata,
    output logic             st_req,
    output logic [31:0]      st_addr,
    output logic [31:0]      st_data,
    input  logic             st_ack,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ST_REQ = 1'b1
    } state_t;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_SW    = 5'b00111;

    // Returns {writes_register, destination}; jal and setx have fixed link registers.
    function automatic logic [5:0] decode_dest(input logic [4:0] op, input logic [4:0] rd);
        logic [5:0] res;
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW: res = {1'b1, rd};
            OP_JAL:                   res = {1'b1, 5'd31};
            OP_SETX:                  res = {1'b1, 5'd30};
            default:                  res = {1'b0, 5'd0};
        endcase
        return res;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [4:0]  op_s;
    logic [4:0]  rd_s;
    logic [5:0]  dest_s;
    logic        head_valid_s;
    logic        is_sw_s;
    logic        capture_s;
    logic        unused_instr_s;

    assign op_s           = rob_head_instr[31:27];
    assign rd_s           = rob_head_instr[26:22];
    assign dest_s         = decode_dest(op_s, rd_s);
    assign head_valid_s   = rob_head_ready & ~rob_empty;
    assign is_sw_s        = (op_s == OP_SW);
    assign rf_raddr       = rd_s;
    assign unused_instr_s = ^rob_head_instr[21:0];

    // Retirement decision: next state, pop and regfile write for the current head.
    always_comb begin
        state_nxt_s = state_r;
        rob_pop     = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = dest_s[4:0];
        rf_wdata    = rob_head_val;
        capture_s   = 1'b0;
        if (reset) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!head_valid_s) begin
                        state_nxt_s = IDLE;
                    end else if (is_sw_s) begin
                        capture_s   = 1'b1;
                        state_nxt_s = ST_REQ;
                    end else begin
                        rob_pop = 1'b1;
                        rf_we   = dest_s[5] & (dest_s[4:0] != 5'd0);
                    end
                end
                ST_REQ: begin
                    if (st_ack) begin
                        rob_pop     = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State, store request registers and retirement counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            st_req       <= 1'b0;
            st_addr      <= 32'd0;
            st_data      <= 32'd0;
            retire_count <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                st_req  <= 1'b1;
                st_addr <= rob_head_val;
                st_data <= rf_rdata;
            end else if ((state_r == ST_REQ) && st_ack) begin
                st_req <= 1'b0;
            end
            if (rob_pop) begin
                retire_count <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Table-driven bench for rob_commit with a queue-based scoreboard of expected outputs.
module tb_rob_commit;

    logic        clock = 1'b0;
    logic        reset;
    logic        rob_empty;
    logic [31:0] rob_head_instr;
    logic [31:0] rob_head_val;
    logic        rob_head_ready;
    logic        rob_pop, rf_we, st_req, st_ack;
    logic [4:0]  rf_waddr, rf_raddr;
    logic [31:0] rf_wdata, rf_rdata, st_addr, st_data, retire_count;

    logic        s_pop, s_we, s_req;
    logic [4:0]  s_waddr, s_raddr;
    logic [31:0] s_wdata, s_addr, s_data;
    logic [2:0]  s_count;

    int n_vec = 0;
    int n_fail = 0;
    logic [31:0] exp_cnt = 32'd0;

    always #5 clock = ~clock;

    rob_commit u_dut (
        .clock(clock), .reset(reset), .rob_empty(rob_empty),
        .rob_head_instr(rob_head_instr), .rob_head_val(rob_head_val),
        .rob_head_ready(rob_head_ready), .rob_pop(rob_pop), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata), .st_req(st_req), .st_addr(st_addr),
        .st_data(st_data), .st_ack(st_ack), .retire_count(retire_count)
    );

    // Narrow counter instance to exercise wrap-around.
    rob_commit #(.CNT_W(3)) u_small (
        .clock(clock), .reset(reset), .rob_empty(rob_empty),
        .rob_head_instr(rob_head_instr), .rob_head_val(rob_head_val),
        .rob_head_ready(rob_head_ready), .rob_pop(s_pop), .rf_we(s_we),
        .rf_waddr(s_waddr), .rf_wdata(s_wdata), .rf_raddr(s_raddr),
        .rf_rdata(rf_rdata), .st_req(s_req), .st_addr(s_addr),
        .st_data(s_data), .st_ack(st_ack), .retire_count(s_count)
    );

    typedef struct {
        logic        rst;
        logic        empty;
        logic [31:0] instr;
        logic [31:0] val;
        logic        ready;
        logic [31:0] rdata;
        logic        ack;
        logic        exp_pop;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic        exp_sreq;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    localparam logic [4:0] RT = 5'b00000, ADDI = 5'b00101, LW = 5'b01000;
    localparam logic [4:0] JAL = 5'b00011, SETX = 5'b10101, SW = 5'b00111, BR = 5'b11111;

    function automatic vec_t mkv(input logic rst, input logic empty, input logic [4:0] op,
                                 input logic [4:0] rd, input logic [31:0] val,
                                 input logic ready, input logic [31:0] rdata,
                                 input logic ack, input logic p, input logic we,
                                 input logic [4:0] wa, input logic sreq);
        vec_t v;
        v.rst = rst; v.empty = empty; v.instr = {op, rd, 22'h155555}; v.val = val;
        v.ready = ready; v.rdata = rdata; v.ack = ack; v.exp_pop = p; v.exp_we = we;
        v.exp_waddr = wa; v.exp_sreq = sreq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clock);
        reset = v.rst; rob_empty = v.empty; rob_head_instr = v.instr;
        rob_head_val = v.val; rob_head_ready = v.ready; rf_rdata = v.rdata; st_ack = v.ack;
        exp_q.push_back(v);
        #2;
        e = exp_q.pop_front();
        chk("rob_pop", {31'd0, rob_pop}, {31'd0, e.exp_pop});
        chk("rf_we", {31'd0, rf_we}, {31'd0, e.exp_we});
        chk("small_pop", {31'd0, s_pop}, {31'd0, e.exp_pop});
        if (e.exp_we) begin
            chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.exp_waddr});
            chk("rf_wdata", rf_wdata, e.val);
        end
        chk("rf_raddr", {27'd0, rf_raddr}, {27'd0, e.instr[26:22]});
        if (e.rst) exp_cnt = 32'd0;
        else if (e.exp_pop) exp_cnt = exp_cnt + 32'd1;
        @(posedge clock);
        #1;
        chk("st_req", {31'd0, st_req}, {31'd0, e.exp_sreq});
        chk("retire_count", retire_count, exp_cnt);
        chk("retire_count_w3", {29'd0, s_count}, {29'd0, exp_cnt[2:0]});
    endtask

    task automatic chk_store(input logic [31:0] a, input logic [31:0] d);
        chk("st_addr", st_addr, a);
        chk("st_data", st_data, d);
    endtask

    initial begin
        reset = 1'b1; rob_empty = 1'b1; rob_head_instr = 32'd0; rob_head_val = 32'd0;
        rob_head_ready = 1'b0; rf_rdata = 32'd0; st_ack = 1'b0;

        // Reset, then empty ROB for 10 cycles (ack while idle is ignored).
        tbl.push_back(mkv(1, 0, ADDI, 5'd4, 32'h9, 1, 32'h0, 1, 0, 0, 5'd0, 0));
        tbl.push_back(mkv(1, 1, RT, 5'd0, 32'h0, 0, 32'h0, 0, 0, 0, 5'd0, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mkv(0, 1, ADDI, 5'd1, 32'h5, 0, 32'h0, i[0], 0, 0, 5'd0, 0));
        // Three back-to-back addi.
        tbl.push_back(mkv(0, 0, ADDI, 5'd1, 32'h11, 1, 32'h0, 0, 1, 1, 5'd1, 0));
        tbl.push_back(mkv(0, 0, ADDI, 5'd2, 32'h22, 1, 32'h0, 0, 1, 1, 5'd2, 0));
        tbl.push_back(mkv(0, 0, ADDI, 5'd3, 32'h33, 1, 32'h0, 0, 1, 1, 5'd3, 0));
        // r0 suppression, fixed-destination ops, non-writers, ready-but-empty.
        tbl.push_back(mkv(0, 0, RT, 5'd0, 32'h77, 1, 32'h0, 0, 1, 0, 5'd0, 0));
        tbl.push_back(mkv(0, 0, JAL, 5'd7, 32'h40, 1, 32'h0, 0, 1, 1, 5'd31, 0));
        tbl.push_back(mkv(0, 0, SETX, 5'd9, 32'h1234, 1, 32'h0, 0, 1, 1, 5'd30, 0));
        tbl.push_back(mkv(0, 0, LW, 5'd5, 32'hCAFE, 1, 32'h0, 0, 1, 1, 5'd5, 0));
        tbl.push_back(mkv(0, 0, RT, 5'd12, 32'hABC, 1, 32'h0, 0, 1, 1, 5'd12, 0));
        tbl.push_back(mkv(0, 0, BR, 5'd6, 32'h66, 1, 32'h0, 0, 1, 0, 5'd0, 0));
        tbl.push_back(mkv(0, 1, ADDI, 5'd8, 32'h88, 1, 32'h0, 0, 0, 0, 5'd0, 0));
        // Head not ready for 5 cycles, then ready.
        for (int i = 0; i < 5; i++)
            tbl.push_back(mkv(0, 0, ADDI, 5'd9, 32'h99, 0, 32'h0, 0, 0, 0, 5'd0, 0));
        tbl.push_back(mkv(0, 0, ADDI, 5'd9, 32'h99, 1, 32'h0, 0, 1, 1, 5'd9, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Store with ack delayed 3 cycles; ROB contents changing meanwhile are ignored.
        apply(mkv(0, 0, SW, 5'd4, 32'h100, 1, 32'hBEEF, 0, 0, 0, 5'd0, 1));
        chk_store(32'h100, 32'hBEEF);
        apply(mkv(0, 0, SW, 5'd4, 32'h100, 1, 32'hDEAD, 0, 0, 0, 5'd0, 1));
        chk_store(32'h100, 32'hBEEF);
        apply(mkv(0, 0, ADDI, 5'd2, 32'h555, 1, 32'hDEAD, 0, 0, 0, 5'd0, 1));
        chk_store(32'h100, 32'hBEEF);
        apply(mkv(0, 1, SW, 5'd4, 32'h200, 0, 32'h0, 0, 0, 0, 5'd0, 1));
        chk_store(32'h100, 32'hBEEF);
        apply(mkv(0, 0, SW, 5'd4, 32'h100, 1, 32'hBEEF, 1, 1, 0, 5'd0, 0));
        apply(mkv(0, 0, ADDI, 5'd10, 32'hA0, 1, 32'h0, 1, 1, 1, 5'd10, 0));

        // Fill counter so the narrow instance wraps, then reset in the middle of a store.
        for (int i = 0; i < 4; i++)
            apply(mkv(0, 0, ADDI, 5'd11, i, 1, 32'h0, 0, 1, 1, 5'd11, 0));
        apply(mkv(0, 0, SW, 5'd3, 32'h300, 1, 32'h1111, 0, 0, 0, 5'd0, 1));
        chk_store(32'h300, 32'h1111);
        apply(mkv(1, 0, SW, 5'd3, 32'h300, 1, 32'h1111, 1, 0, 0, 5'd0, 0));
        chk_store(32'h0, 32'h0);
        apply(mkv(0, 0, SW, 5'd3, 32'h300, 1, 32'h2222, 0, 0, 0, 5'd0, 1));
        chk_store(32'h300, 32'h2222);
        apply(mkv(0, 0, SW, 5'd3, 32'h300, 1, 32'h2222, 1, 1, 0, 5'd0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
